// File: rtl/dac_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_bus_pkg
// Purpose  : Shared state encoding, defaults and arbitration helper for the
//            RAMDAC / PHY shared-bus write arbiter.
// Revision : 1.0  initial release
// ============================================================================
package dac_bus_pkg;

    localparam int DEFAULT_DIV          = 4;
    localparam int DEFAULT_STROBE_TICKS = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Two-way round robin: a tie goes to whoever was not granted last.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational two-requester round-robin winner selection.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2
    import dac_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = rr_pick(req, last);

endmodule
`default_nettype wire

// File: rtl/dac_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dac_bus_arbiter
// Purpose  : Arbitrates RAMDAC and PHY register writes onto one shared RS/data
//            bus, sequencing SETUP / STROBE / HOLD on a divided bus tick.
// Revision : 1.0  initial release
// ============================================================================
module dac_bus_arbiter
    import dac_bus_pkg::*;
#(
    parameter int DIV          = DEFAULT_DIV,
    parameter int STROBE_TICKS = DEFAULT_STROBE_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] rs0,
    input  logic [2:0] rs1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic       bus_oe,
    output logic [2:0] bus_rs,
    output logic [7:0] bus_data,
    output logic       dac_wr_n,
    output logic       phy_wr_n,
    output logic       busy,
    output logic       gnt
);

    localparam int CW = $clog2(DIV);
    localparam int SW = (STROBE_TICKS > 1) ? $clog2(STROBE_TICKS) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] c_STB_LAST = SW'(STROBE_TICKS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("dac_bus_arbiter: DIV must be at least 2");
    end
    if (STROBE_TICKS < 1) begin : g_bad_strobe
        $error("dac_bus_arbiter: STROBE_TICKS must be at least 1");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            w_tick;
    logic [SW-1:0]   r_stb_cnt;
    logic [SW-1:0]   w_stb_cnt_nxt;
    logic            r_last;
    logic            w_last_nxt;
    logic            w_gnt_nxt;
    logic [2:0]      w_rs_nxt;
    logic [7:0]      w_data_nxt;
    logic            w_ack0_nxt;
    logic            w_ack1_nxt;
    logic            w_oe_nxt;
    logic            w_dac_wr_n_nxt;
    logic            w_phy_wr_n_nxt;
    logic            w_arb_valid;
    logic            w_arb_winner;

    // Free-running bus tick divider; restarts from zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_tick = (r_cnt == c_CNT_LAST);

    rr_arb2 u_rr_arb2 (
        .req    ({req1, req0}),
        .last   (r_last),
        .valid  (w_arb_valid),
        .winner (w_arb_winner)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_stb_cnt_nxt = r_stb_cnt;
        w_last_nxt    = r_last;
        w_gnt_nxt     = gnt;
        w_rs_nxt      = bus_rs;
        w_data_nxt    = bus_data;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        w_state_nxt = ST_SETUP;
                        w_gnt_nxt   = w_arb_winner;
                        w_last_nxt  = w_arb_winner;
                        w_rs_nxt    = w_arb_winner ? rs1 : rs0;
                        w_data_nxt  = w_arb_winner ? wdata1 : wdata0;
                    end
                end
                ST_SETUP: begin
                    w_state_nxt   = ST_STROBE;
                    w_stb_cnt_nxt = '0;
                end
                ST_STROBE: begin
                    if (r_stb_cnt == c_STB_LAST) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_stb_cnt_nxt = r_stb_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Bus returns to zero while idle so the pins carry no stale value.
                    w_state_nxt = ST_IDLE;
                    w_rs_nxt    = 3'd0;
                    w_data_nxt  = 8'd0;
                    w_ack0_nxt  = ~gnt;
                    w_ack1_nxt  = gnt;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with r_state.
        w_oe_nxt       = (w_state_nxt != ST_IDLE);
        w_dac_wr_n_nxt = ~((w_state_nxt == ST_STROBE) && !w_gnt_nxt);
        w_phy_wr_n_nxt = ~((w_state_nxt == ST_STROBE) &&  w_gnt_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_stb_cnt <= '0;
            r_last    <= 1'b1;
            gnt       <= 1'b0;
            bus_oe    <= 1'b0;
            bus_rs    <= 3'd0;
            bus_data  <= 8'd0;
            dac_wr_n  <= 1'b1;
            phy_wr_n  <= 1'b1;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_stb_cnt <= w_stb_cnt_nxt;
            r_last    <= w_last_nxt;
            gnt       <= w_gnt_nxt;
            bus_oe    <= w_oe_nxt;
            bus_rs    <= w_rs_nxt;
            bus_data  <= w_data_nxt;
            dac_wr_n  <= w_dac_wr_n_nxt;
            phy_wr_n  <= w_phy_wr_n_nxt;
            ack0      <= w_ack0_nxt;
            ack1      <= w_ack1_nxt;
            busy      <= w_oe_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_bus_arbiter
// Purpose  : Self-checking bench for dac_bus_arbiter (default build plus a
//            DIV=2 / STROBE_TICKS=3 build).
// Revision : 1.0  initial release
// ============================================================================
module tb_dac_bus_arbiter;
    import dac_bus_pkg::*;

    localparam int DIV  = DEFAULT_DIV;
    localparam int STB  = DEFAULT_STROBE_TICKS;
    localparam int WLEN = (2 + STB) * DIV;
    localparam logic [17:0] RST_VEC = {2'b00, 1'b0, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] rs0 = 3'd0, rs1 = 3'd0;
    logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
    logic       ack0, ack1, bus_oe, dac_wr_n, phy_wr_n, busy, gnt;
    logic [2:0] bus_rs;
    logic [7:0] bus_data;

    logic       b_req0 = 1'b0, b_req1 = 1'b0;
    logic [2:0] b_rs0 = 3'd0, b_rs1 = 3'd0;
    logic [7:0] b_wdata0 = 8'd0, b_wdata1 = 8'd0;
    logic       b_ack0, b_ack1, b_oe, b_dac_wr_n, b_phy_wr_n, b_busy, b_gnt;
    logic [2:0] b_rs;
    logic [7:0] b_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dac_bus_arbiter u_dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
        .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1), .bus_oe(bus_oe),
        .bus_rs(bus_rs), .bus_data(bus_data), .dac_wr_n(dac_wr_n), .phy_wr_n(phy_wr_n),
        .busy(busy), .gnt(gnt)
    );

    dac_bus_arbiter #(.DIV(2), .STROBE_TICKS(3)) u_dut2 (
        .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .rs0(b_rs0), .rs1(b_rs1),
        .wdata0(b_wdata0), .wdata1(b_wdata1), .ack0(b_ack0), .ack1(b_ack1), .bus_oe(b_oe),
        .bus_rs(b_rs), .bus_data(b_data), .dac_wr_n(b_dac_wr_n), .phy_wr_n(b_phy_wr_n),
        .busy(b_busy), .gnt(b_gnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a write is a window of WLEN clocks starting after a tick;
    // the strobe occupies the middle STB*DIV clocks of that window.
    int          m_phase, m_pos;
    logic        m_active, m_own, m_last, m_ack0, m_ack1;
    logic [2:0]  m_rs;
    logic [7:0]  m_data;

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_active = 1'b0; m_own = 1'b0; m_last = 1'b1;
        m_rs = 3'd0; m_data = 8'd0; m_ack0 = 1'b0; m_ack1 = 1'b0;
    endtask

    task automatic model_step();
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (m_active) begin
            if (m_pos == WLEN - 1) begin
                m_active = 1'b0;
                m_ack0   = !m_own;
                m_ack1   = m_own;
            end else begin
                m_pos++;
            end
        end else if (m_phase == DIV - 1 && (req0 || req1)) begin
            m_own    = (req0 && req1) ? !m_last : req1;
            m_last   = m_own;
            m_active = 1'b1;
            m_pos    = 0;
            m_rs     = m_own ? rs1 : rs0;
            m_data   = m_own ? wdata1 : wdata0;
        end
        m_phase = (m_phase + 1) % DIV;
    endtask

    function automatic logic [17:0] model_outs();
        logic stb;
        stb = m_active && (m_pos >= DIV) && (m_pos < DIV + STB * DIV);
        return {m_ack0, m_ack1, m_active, m_active ? m_rs : 3'b000, m_active ? m_data : 8'h00,
                !(stb && !m_own), !(stb && m_own), m_active, m_own};
    endfunction

    logic [17:0] act_vec;
    logic        prev_stb = 1'b0, stb_now;
    logic [10:0] prev_bus = 11'd0;

    initial begin : p_check
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            act_vec = {ack0, ack1, bus_oe, bus_rs, bus_data, dac_wr_n, phy_wr_n, busy, gnt};
            chk("model_cycle", 32'(act_vec), 32'(model_outs()));
            stb_now = !dac_wr_n || !phy_wr_n;
            tests++;
            if ((!dac_wr_n && !phy_wr_n) || (stb_now && !bus_oe) ||
                (stb_now && prev_stb && ({bus_rs, bus_data} != prev_bus)) ||
                (!b_dac_wr_n && !b_phy_wr_n) || ((!b_dac_wr_n || !b_phy_wr_n) && !b_oe)) begin
                fails++;
                $display("FAIL bus_invariant: got dac_wr_n=%b phy_wr_n=%b oe=%b bus=%h prev=%h b_wr_n=%b%b b_oe=%b, expected one strobe max, oe high, bus stable (t=%0t)",
                         dac_wr_n, phy_wr_n, bus_oe, {bus_rs, bus_data}, prev_bus,
                         b_dac_wr_n, b_phy_wr_n, b_oe, $time);
            end
            prev_stb = stb_now;
            prev_bus = {bus_rs, bus_data};
            if (!rst) model_step();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; b_req1 = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       r0;
        logic       r1;
        logic [2:0] rs0;
        logic [2:0] rs1;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nwr;
        logic [7:0] seq;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int idx, input vec_t v);
        int          nack, oe_len, stb_len, gap, budget;
        logic        in_gap, who, stb_who;
        logic [10:0] stb_val;
        nack = 0; oe_len = 0; stb_len = 0; gap = 0; budget = 0;
        in_gap = 1'b0; stb_who = 1'b0; stb_val = 11'd0;
        do_reset();
        req0 = v.r0; req1 = v.r1; rs0 = v.rs0; rs1 = v.rs1; wdata0 = v.d0; wdata1 = v.d1;
        while (nack < v.nwr && budget < 40 * v.nwr + 20) begin
            cyc();
            budget++;
            if (bus_oe) begin
                if (in_gap) begin
                    chk($sformatf("v%0d_idle_gap", idx), 32'(gap >= DIV), 32'd1);
                    in_gap = 1'b0;
                end
                oe_len++;
            end else if (in_gap) begin
                gap++;
            end
            if (!dac_wr_n || !phy_wr_n) begin
                stb_len++;
                stb_who = !phy_wr_n;
                stb_val = {bus_rs, bus_data};
            end
            if (ack0 || ack1) begin
                who = v.seq[nack];
                chk($sformatf("v%0d_w%0d_ack", idx, nack), 32'({ack0, ack1}), 32'({!who, who}));
                chk($sformatf("v%0d_w%0d_oe_len", idx, nack), oe_len, WLEN);
                chk($sformatf("v%0d_w%0d_stb_len", idx, nack), stb_len, STB * DIV);
                chk($sformatf("v%0d_w%0d_stb_who", idx, nack), 32'(stb_who), 32'(who));
                chk($sformatf("v%0d_w%0d_bus", idx, nack), 32'(stb_val),
                    32'(who ? {v.rs1, v.d1} : {v.rs0, v.d0}));
                nack++;
                oe_len = 0; stb_len = 0;
                in_gap = 1'b1;
                gap = bus_oe ? 0 : 1;
            end
        end
        chk($sformatf("v%0d_writes_done", idx), nack, v.nwr);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin : p_main
        int n, n_ack, t, t_setup, t_ack, low, dac_low;
        logic pend0, pend1;
        logic [10:0] b_val;

        vecs[0] = '{1'b1, 1'b0, 3'b110, 3'b000, 8'h81, 8'h00, 1, 8'b0000_0000};
        vecs[1] = '{1'b1, 1'b1, 3'b001, 3'b111, 8'h11, 8'hEE, 2, 8'b0000_0010};
        vecs[2] = '{1'b1, 1'b1, 3'b011, 3'b100, 8'hA5, 8'h5A, 6, 8'b0010_1010};
        vecs[3] = '{1'b0, 1'b1, 3'b000, 3'b101, 8'h00, 8'hC3, 3, 8'b0000_0111};
        vecs[4] = '{1'b1, 1'b0, 3'b010, 3'b000, 8'h7E, 8'h00, 2, 8'b0000_0000};

        cyc();
        cyc();
        chk("reset_state", 32'({ack0, ack1, bus_oe, bus_rs, bus_data, dac_wr_n, phy_wr_n, busy, gnt}),
            32'(RST_VEC));
        chk("reset_state_dut2", 32'({b_ack0, b_ack1, b_oe, b_rs, b_data, b_dac_wr_n, b_phy_wr_n, b_busy, b_gnt}),
            32'(RST_VEC));
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a strobe aborts the write with no ack.
        do_reset();
        req0 = 1'b1; rs0 = 3'b101; wdata0 = 8'h3C;
        n = 0;
        while (dac_wr_n && n < 60) begin cyc(); n++; end
        chk("strobe_reached", 32'(dac_wr_n), 32'd0);
        cyc();
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_strobe", 32'({ack0, ack1, bus_oe, bus_rs, bus_data, dac_wr_n, phy_wr_n, busy, gnt}),
            32'(RST_VEC));
        req0 = 1'b0;
        cyc();
        rst = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 40; i++) begin cyc(); if (ack0 || ack1) n_ack++; end
        chk("no_ack_after_abort", n_ack, 0);

        // Request withdrawn before the first tick is never granted.
        do_reset();
        req1 = 1'b1; rs1 = 3'b011; wdata1 = 8'h99;
        cyc();
        req1 = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin cyc(); if (bus_oe) n++; end
        chk("early_drop_ignored", n, 0);

        // Request withdrawn after grant still completes.
        do_reset();
        req0 = 1'b1; rs0 = 3'b100; wdata0 = 8'h42;
        n = 0;
        while (!busy && n < 20) begin cyc(); n++; end
        req0 = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 30; i++) begin cyc(); if (ack0) n_ack++; end
        chk("late_drop_completes", n_ack, 1);

        // Randomized traffic, checked cycle by cycle against the model.
        do_reset();
        pend0 = 1'b0; pend1 = 1'b0; n_ack = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (ack0 || ack1) n_ack++;
            if (pend0) begin
                if (ack0) begin req0 = 1'b0; pend0 = 1'b0; end
                else if ($urandom_range(0, 15) == 0) begin
                    req0 = 1'b0; pend0 = 1'b0; wdata0 = 8'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                req0 = 1'b1; pend0 = 1'b1; rs0 = 3'($urandom); wdata0 = 8'($urandom);
            end
            if (pend1) begin
                if (ack1) begin req1 = 1'b0; pend1 = 1'b0; end
                else if ($urandom_range(0, 15) == 0) begin
                    req1 = 1'b0; pend1 = 1'b0; rs1 = 3'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                req1 = 1'b1; pend1 = 1'b1; rs1 = 3'($urandom); wdata1 = 8'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1; req0 = 1'b0; req1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
                cyc();
                rst = 1'b0;
            end
        end
        chk("random_activity", 32'(n_ack > 20), 32'd1);

        // DIV=2, STROBE_TICKS=3 build: PHY write timing.
        do_reset();
        b_req1 = 1'b1; b_rs1 = 3'b010; b_wdata1 = 8'hFF;
        t = 0; t_setup = -1; t_ack = -1; low = 0; dac_low = 0; b_val = 11'd0;
        while (t_ack < 0 && t < 100) begin
            cyc();
            t++;
            if (b_oe && t_setup < 0) t_setup = t;
            if (!b_phy_wr_n) begin low++; b_val = {b_rs, b_data}; end
            if (!b_dac_wr_n) dac_low++;
            if (b_ack1) t_ack = t;
        end
        b_req1 = 1'b0;
        chk("dut2_ack_seen", 32'(t_ack > 0), 32'd1);
        chk("dut2_phy_low", low, 6);
        chk("dut2_latency", t_ack - t_setup, 10);
        chk("dut2_dac_idle", dac_low, 0);
        chk("dut2_bus", 32'(b_val), 32'({3'b010, 8'hFF}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dac_bus_arbiter.md
DAC_BUS_ARBITER -- requirements
Module: dac_bus_arbiter

Interface
REQ-001 SHALL have parameter DIV, default 4: number of clk cycles per bus tick, minimum 2.
REQ-002 SHALL have parameter STROBE_TICKS, default 1: number of ticks the write strobe is held low, minimum 1.
REQ-003 SHALL have port clk  input  1  single clock; every register SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports req0/req1  input  1 each  write request; requester 0 is the RAMDAC programmer, requester 1 is the ethernet PHY.
REQ-006 SHALL have ports rs0/rs1  input  3 each  register-select value for the requester's write.
REQ-007 SHALL have ports wdata0/wdata1  input  8 each  data value for the requester's write.
REQ-008 SHALL have ports ack0/ack1  output  1 each  one-clk pulse marking completion of that requester's write.
REQ-009 SHALL have port bus_oe  output  1  drive enable for the shared RS and data pins; the top level SHALL tristate the pins when it is 0.
REQ-010 SHALL have ports bus_rs (output, 3) and bus_data (output, 8): values driven onto the shared pins.
REQ-011 SHALL have ports dac_wr_n/phy_wr_n  output  1 each  active-low write strobes to the RAMDAC and PHY.
REQ-012 SHALL have ports busy (output, 1) and gnt (output, 1): busy is high in any non-IDLE state; gnt is the index of the current owner.

Function
REQ-013 A free-running tick counter SHALL count 0..DIV-1; tick is high for one clk when the count is DIV-1.
REQ-014 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD; state changes occur only on tick cycles.
REQ-015 IDLE: on tick with any request pending, the FSM SHALL latch the winner's rs/wdata and gnt, then enter SETUP; with no request it stays in IDLE.
REQ-016 Arbitration SHALL be round-robin: on a tie the requester not granted last wins; the last-granted pointer resets to 1, so requester 0 wins the first tie.
REQ-017 A single requester SHALL be granted on every cycle it requests, with no fairness penalty.
REQ-018 SETUP: bus_oe=1, bus_rs/bus_data=latched values, strobes high; on the next tick the FSM SHALL enter STROBE.
REQ-019 STROBE: the granted requester's wr_n SHALL be 0 and the other strobe 1; after STROBE_TICKS ticks the FSM SHALL enter HOLD.
REQ-020 HOLD: bus values held, strobes high; on the next tick the FSM SHALL enter IDLE and pulse ack[gnt] for exactly one clk on that cycle.
REQ-021 In IDLE, bus_oe SHALL be 0; bus_rs/bus_data SHALL be 0, giving at least one idle tick of turnaround between consecutive writes.
REQ-022 Requesters SHALL hold req/rs/wdata stable until ack; the block SHALL use only the values latched at grant.
REQ-023 A request deasserted before grant SHALL be ignored; a request deasserted after grant SHALL NOT abort the cycle.
REQ-024 Write cycle length from entering SETUP to ack SHALL be (2+STROBE_TICKS)*DIV clk.
REQ-025 Both strobes SHALL never be low in the same cycle, and a strobe SHALL never be low while bus_oe=0.

Reset
REQ-026 On reset assertion, the block SHALL immediately force: state=IDLE, tick count=0, pointer=1, gnt=0, bus_oe=0, bus_rs=0, bus_data=0, dac_wr_n=1, phy_wr_n=1, ack0=ack1=0, busy=0.
REQ-027 Reset asserted mid-cycle SHALL abort the write with no ack; after release, the first tick occurs DIV clk later.

Structure
REQ-028 State encodings and the DIV and STROBE_TICKS defaults SHALL live in a shared package, dac_bus_pkg.
REQ-029 The round-robin winner logic MAY be a sub-module, rr_arb2; all other logic SHALL be in one module.

Verification
REQ-030 Scenario: req0 only, rs0=3'b110, wdata0=8'h81, defaults -> bus_oe high 12 clk; dac_wr_n low 4 clk; phy_wr_n stays 1; ack0 pulses once.
REQ-031 Scenario: req0 and req1 asserted in the same cycle after reset -> requester 0 served first, then requester 1; at least one idle tick with bus_oe=0 between the two writes.
REQ-032 Scenario: both requests held continuously for 6 writes -> grants alternate 0,1,0,1,0,1.
REQ-033 Scenario: rst pulsed during STROBE -> dac_wr_n=1 and bus_oe=0 in the same cycle; no ack issued.
REQ-034 Scenario: DIV=2, STROBE_TICKS=3, req1 with rs1=3'b010, wdata1=8'hFF -> phy_wr_n low 6 clk; ack1 arrives 10 clk after SETUP entry.
REQ-035 Scenario: assertion checks for the whole run -> never both strobes low; rs and data stable while any strobe is low.
